// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   state_t : sequencer states
//   REG_X0  : architectural zero register, never a real dependency
//   ctrl_t  : bundle of pipeline control strobes driven by the sequencer
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic mc_start;
    } ctrl_t;

    // Free-running pipeline: everything advances, nothing squashed.
    localparam ctrl_t CTRL_RUN = 7'b1101000;
    // Held in reset: nothing advances, both downstream registers take NOPs.
    localparam ctrl_t CTRL_RST = 7'b0000110;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently in EX. Forwarding cannot cover this case because the
// load data only exists after MEM.
// Ports:
//   rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID : ID source operands and usage
//   rd_EX, mem_read_EX                     : EX destination and load flag
//   load_use                               : one-cycle stall required
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1_ID,
    input  logic       use_rs2_ID,
    input  logic [4:0] rd_EX,
    input  logic       mem_read_EX,
    output logic       load_use
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1  = use_rs1_ID && (rs1_ID == rd_EX);
    assign hit_rs2  = use_rs2_ID && (rs2_ID == rd_EX);
    // A load to x0 is discarded, so nothing actually depends on it.
    assign load_use = mem_read_EX && (rd_EX != REG_X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage core. Each cycle decides whether the PC
// and pipeline registers advance, hold, or take a bubble, covering load-use
// stalls, EX mispredict flushes, multi-cycle EX ops and halt drain.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   rs1/rs2/use_rs1/use_rs2_ID   : ID operand usage
//   halt_ID                      : ID instruction is ecall/halt
//   rd_EX, mem_read_EX           : EX load destination
//   mc_op_EX, mc_done            : multi-cycle op in EX / unit result pulse
//   mispredict_EX                : EX branch resolved against prediction
//   pc_write .. mc_start         : pipeline control strobes
//   is_halted                    : registered, sticky until reset
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1_ID,
    input  logic       use_rs2_ID,
    input  logic       halt_ID,
    input  logic [4:0] rd_EX,
    input  logic       mem_read_EX,
    input  logic       mc_op_EX,
    input  logic       mc_done,
    input  logic       mispredict_EX,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_bubble,
    output logic       ex_mem_bubble,
    output logic       mc_start,
    output logic       is_halted
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q;
    logic             load_use;
    ctrl_t            ctrl;

    load_use_detect u_lud (
        .rs1_ID      (rs1_ID),
        .rs2_ID      (rs2_ID),
        .use_rs1_ID  (use_rs1_ID),
        .use_rs2_ID  (use_rs2_ID),
        .rd_EX       (rd_EX),
        .mem_read_EX (mem_read_EX),
        .load_use    (load_use)
    );

    // State register, drain counter and sticky halt flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // Set on entry so it is visible in the first HALTED cycle.
            halted_q <= halted_q | (state_d == HALTED);
        end
    end

    // Next-state logic. Mispredict and load-use never change state; the
    // mispredict check must come first so a flushed halt/mc op is not acted on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (mispredict_EX) begin
                    state_d = RUN;
                end else if (mc_op_EX) begin
                    state_d = MC_WAIT;
                end else if (load_use) begin
                    state_d = RUN;
                end else if (halt_ID) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            MC_WAIT: begin
                if (mc_done) state_d = RUN;
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = HALTED;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Output decode.
    always_comb begin
        ctrl = CTRL_RUN;
        unique case (state_q)
            RUN: begin
                if (mispredict_EX) begin
                    // PC takes the redirect; wrong-path IF and ID are squashed.
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (mc_op_EX) begin
                    ctrl.pc_write      = 1'b0;
                    ctrl.if_id_write   = 1'b0;
                    ctrl.id_ex_write   = 1'b0;
                    ctrl.ex_mem_bubble = 1'b1;
                    ctrl.mc_start      = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_write     = 1'b0;
                    ctrl.if_id_write  = 1'b0;
                    ctrl.id_ex_bubble = 1'b1;
                end
                // Halt acceptance: the halt instr advances normally.
            end
            MC_WAIT: begin
                // On mc_done everything advances and the result lands in EX/MEM.
                if (!mc_done) begin
                    ctrl.pc_write      = 1'b0;
                    ctrl.if_id_write   = 1'b0;
                    ctrl.id_ex_write   = 1'b0;
                    ctrl.ex_mem_bubble = 1'b1;
                end
            end
            DRAIN: begin
                ctrl.pc_write     = 1'b0;
                ctrl.if_id_write  = 1'b0;
                ctrl.id_ex_bubble = 1'b1;
            end
            HALTED: begin
                ctrl.pc_write      = 1'b0;
                ctrl.if_id_write   = 1'b0;
                ctrl.id_ex_bubble  = 1'b1;
                ctrl.ex_mem_bubble = 1'b1;
            end
            default: ctrl = CTRL_RUN;
        endcase
        // Reset overrides immediately, before the next clock edge.
        if (!reset_n) ctrl = CTRL_RST;
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign mc_start      = ctrl.mc_start;
    assign is_halted     = halted_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Inputs change 1ns after the rising
// edge; outputs are compared at the falling edge against hand-computed vectors
// {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//  ex_mem_bubble, mc_start, is_halted}.
module tb_hazard_control_unit;

    localparam logic [7:0] V_RST  = 8'b0000_1100;
    localparam logic [7:0] V_RUN  = 8'b1101_0000;
    localparam logic [7:0] V_LU   = 8'b0001_1000;
    localparam logic [7:0] V_MISP = 8'b1111_1000;
    localparam logic [7:0] V_MCS  = 8'b0000_0110;
    localparam logic [7:0] V_MCW  = 8'b0000_0100;
    localparam logic [7:0] V_DRN  = 8'b0001_1000;
    localparam logic [7:0] V_HLT  = 8'b0001_1101;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       use_rs1_ID, use_rs2_ID, halt_ID;
    logic       mem_read_EX, mc_op_EX, mc_done, mispredict_EX;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write;
    logic       id_ex_bubble, ex_mem_bubble, mc_start, is_halted;
    logic [7:0] outs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.DRAIN_CYCLES(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rs1_ID        (rs1_ID),
        .rs2_ID        (rs2_ID),
        .use_rs1_ID    (use_rs1_ID),
        .use_rs2_ID    (use_rs2_ID),
        .halt_ID       (halt_ID),
        .rd_EX         (rd_EX),
        .mem_read_EX   (mem_read_EX),
        .mc_op_EX      (mc_op_EX),
        .mc_done       (mc_done),
        .mispredict_EX (mispredict_EX),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_write   (id_ex_write),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_bubble (ex_mem_bubble),
        .mc_start      (mc_start),
        .is_halted     (is_halted)
    );

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write,
                   id_ex_bubble, ex_mem_bubble, mc_start, is_halted};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic mc, input logic done,
                       input logic mis, input logic hlt);
        rs1_ID = rs1; rs2_ID = rs2; use_rs1_ID = u1; use_rs2_ID = u2;
        rd_EX = rd; mem_read_EX = mr; mc_op_EX = mc; mc_done = done;
        mispredict_EX = mis; halt_ID = hlt;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare at the falling edge, then advance past the next rising edge.
    task automatic step(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        mc_op_EX = 1'b1;            // reset must suppress mc_start
        repeat (2) @(posedge clk);
        #1;
        step("reset", V_RST);
        reset_n = 1'b1;
        idle();
        step("idle", V_RUN);

        // Load-use on rs1: exactly one stall cycle.
        drv(5'd5, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs1", V_LU);
        idle();
        step("lu_rs1_after", V_RUN);
        // Load-use on rs2.
        drv(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs2", V_LU);
        // Register matches but operand unused.
        drv(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_rs2_unused", V_RUN);
        // Load to x0 is not a hazard.
        drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_x0", V_RUN);
        // Match without a load is not a hazard.
        drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("no_load", V_RUN);

        // Mispredict wins over load-use and halt; no state change.
        drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step("misp_lu", V_MISP);
        idle();
        step("misp_after", V_RUN);

        // Multi-cycle op, mc_done three cycles after mc_start; hazards
        // presented during the wait must be ignored.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mc_start", V_MCS);
        drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step("mc_wait1", V_MCW);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mc_wait2", V_MCW);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("mc_done", V_RUN);
        idle();
        step("mc_after", V_RUN);
        // Stray mc_done in RUN.
        mc_done = 1'b1;
        step("done_in_run", V_RUN);
        idle();
        step("done_in_run_after", V_RUN);

        // Reset during MC_WAIT.
        mc_op_EX = 1'b1;
        step("mc2_start", V_MCS);
        step("mc2_wait", V_MCW);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mc_async", outs, V_RST);
        step("rst_mid_mc", V_RST);
        reset_n = 1'b1;
        idle();
        step("post_rst_run", V_RUN);
        mc_done = 1'b1;
        step("post_rst_done", V_RUN);
        idle();
        step("post_rst_idle", V_RUN);

        // Halt behind a multi-cycle op: MC sequence first, then halt accepted.
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("hmc_start", V_MCS);
        step("hmc_wait1", V_MCW);
        step("hmc_wait2", V_MCW);
        mc_done = 1'b1;
        step("hmc_done", V_RUN);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("halt_accept", V_RUN);
        idle();
        step("drain1", V_DRN);
        mispredict_EX = 1'b1;
        step("drain2", V_DRN);
        idle();
        step("drain3", V_DRN);
        step("drain4", V_DRN);
        step("halted1", V_HLT);
        drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("halted2", V_HLT);
        idle();
        step("halted3", V_HLT);

        reset_n = 1'b0;
        step("rst_halted", V_RST);
        reset_n = 1'b1;
        step("post_halt_run", V_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
